// File: rtl/sequenciador_multiciclo_pkg.sv
// Shared encodings for the multi-cycle sequencer.
//   state_e : FSM state encodings driven on estado
//   class_e : decoded instruction classes presented on instr_class
package seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CLASS_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_EX   = 3'b010,
    ST_MEM  = 3'b011,
    ST_WB   = 3'b100,
    ST_HALT = 3'b110,
    ST_IDLE = 3'b111
  } state_e;

  typedef enum logic [CLASS_W-1:0] {
    CL_ALU_R  = 3'd0,
    CL_ALU_I  = 3'd1,
    CL_LOAD   = 3'd2,
    CL_STORE  = 3'd3,
    CL_BRANCH = 3'd4
  } class_e;

  // Any encoding above BRANCH is an illegal class.
  function automatic logic is_legal(input logic [CLASS_W-1:0] c);
    return (c <= CL_BRANCH);
  endfunction

endpackage

// File: rtl/sequenciador_multiciclo_if.sv
// Control bundle between the sequencer and the datapath / memories.
//   master : the sequencer (drives pc, estado, requests, enables, status, counters)
//   slave  : the datapath side (drives start, ready handshakes, class, branch info)
interface sequenciador_multiciclo_if #(
  parameter int unsigned XLEN = 32
);
  import seq_pkg::*;

  logic                start;
  logic                imem_ready;
  logic                dmem_ready;
  logic [CLASS_W-1:0]  instr_class;
  logic                branch_taken;
  logic [XLEN-1:0]     branch_off;

  logic [XLEN-1:0]     pc;
  logic [STATE_W-1:0]  estado;
  logic                imem_req;
  logic                dmem_req;
  logic                dmem_we;
  logic                ir_en;
  logic                alu_en;
  logic                rf_we;
  logic                retire;
  logic                halted;
  logic                illegal;
  logic [XLEN-1:0]     cycle_count;
  logic [XLEN-1:0]     instret;

  modport master (
    input  start, imem_ready, dmem_ready, instr_class, branch_taken, branch_off,
    output pc, estado, imem_req, dmem_req, dmem_we, ir_en, alu_en, rf_we,
           retire, halted, illegal, cycle_count, instret
  );

  modport slave (
    output start, imem_ready, dmem_ready, instr_class, branch_taken, branch_off,
    input  pc, estado, imem_req, dmem_req, dmem_we, ir_en, alu_en, rf_we,
           retire, halted, illegal, cycle_count, instret
  );

endinterface

// File: rtl/sequenciador_multiciclo_pc_unit.sv
// Next-PC computation and end-of-program compare.
//   i_pc         : current word index
//   i_taken      : select branch target instead of pc+1
//   i_branch_off : signed word offset (two's complement, wraps mod 2^XLEN)
//   o_next_pc_c  : next word index
//   o_halt_c     : next index lies outside the program (unsigned compare)
module pc_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PROG_LEN = 8
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_taken,
  input  logic [XLEN-1:0] i_branch_off,
  output logic [XLEN-1:0] o_next_pc_c,
  output logic            o_halt_c
);

  logic [XLEN-1:0] w_incr;

  // A negative offset that wraps below zero becomes a huge index and halts.
  assign w_incr      = i_taken ? i_branch_off : XLEN'(1);
  assign o_next_pc_c = i_pc + w_incr;
  assign o_halt_c    = (o_next_pc_c >= XLEN'(PROG_LEN));

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Multi-cycle control sequencer: owns the PC, walks IF/ID/EX/MEM/WB skipping
// stages the instruction class does not need, waits on memory ready handshakes,
// and halts on program end or an illegal class.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sequenciador_multiciclo_if.master (handshakes, enables, pc, status)
// Optional: define SEQ_PERF_EN to build the cycle_count / instret counters;
// otherwise both ports read 0.
module sequenciador_multiciclo
  import seq_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PROG_LEN = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  sequenciador_multiciclo_if.master     bus
);

  state_e             r_state;
  state_e             w_next_state;
  logic [XLEN-1:0]    r_pc;
  logic [CLASS_W-1:0] r_class;
  logic               r_halted;
  logic               r_illegal;

  logic               w_imem_req;
  logic               w_dmem_req;
  logic               w_dmem_we;
  logic               w_ir_en;
  logic               w_alu_en;
  logic               w_rf_we;
  logic               w_retire;
  logic               w_taken;
  logic [XLEN-1:0]    w_next_pc;
  logic               w_pc_halt;

  // Taken only matters for a branch retiring out of EX.
  assign w_taken = (r_state == ST_EX) && (r_class == CL_BRANCH) && bus.branch_taken;

  pc_unit #(
    .XLEN     (XLEN),
    .PROG_LEN (PROG_LEN)
  ) u_pc_unit (
    .i_pc         (r_pc),
    .i_taken      (w_taken),
    .i_branch_off (bus.branch_off),
    .o_next_pc_c  (w_next_pc),
    .o_halt_c     (w_pc_halt)
  );

  // State register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_class   <= CL_ALU_R;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_ID) begin
        r_class <= bus.instr_class;
        if (!is_legal(bus.instr_class)) r_illegal <= 1'b1;
      end
      if (w_retire) begin
        r_pc <= w_next_pc;
        if (w_pc_halt) r_halted <= 1'b1;
      end
    end
  end

  // Next state and stage enables.
  always_comb begin
    w_next_state = r_state;
    w_imem_req   = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    w_ir_en      = 1'b0;
    w_alu_en     = 1'b0;
    w_rf_we      = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next_state = ST_IF;
      end
      ST_IF: begin
        w_imem_req = 1'b1;
        if (bus.imem_ready) begin
          w_ir_en      = 1'b1;
          w_next_state = ST_ID;
        end
      end
      ST_ID: begin
        w_next_state = is_legal(bus.instr_class) ? ST_EX : ST_HALT;
      end
      ST_EX: begin
        w_alu_en = 1'b1;
        case (r_class)
          CL_ALU_R, CL_ALU_I: w_next_state = ST_WB;
          CL_LOAD, CL_STORE:  w_next_state = ST_MEM;
          CL_BRANCH: begin
            w_retire     = 1'b1;
            w_next_state = w_pc_halt ? ST_HALT : ST_IF;
          end
          default:            w_next_state = ST_HALT;
        endcase
      end
      ST_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (r_class == CL_STORE);
        if (bus.dmem_ready) begin
          if (r_class == CL_STORE) begin
            w_retire     = 1'b1;
            w_next_state = w_pc_halt ? ST_HALT : ST_IF;
          end else begin
            w_next_state = ST_WB;
          end
        end
      end
      ST_WB: begin
        w_rf_we      = 1'b1;
        w_retire     = 1'b1;
        w_next_state = w_pc_halt ? ST_HALT : ST_IF;
      end
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_IDLE;
    endcase
  end

`ifdef SEQ_PERF_EN
  logic [XLEN-1:0] r_cycle_count;
  logic [XLEN-1:0] r_instret;

  // Active-cycle and retired-instruction counters, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_count <= '0;
      r_instret     <= '0;
    end else begin
      if ((r_state != ST_IDLE) && (r_state != ST_HALT))
        r_cycle_count <= r_cycle_count + XLEN'(1);
      if (w_retire)
        r_instret <= r_instret + XLEN'(1);
    end
  end

  assign bus.cycle_count = r_cycle_count;
  assign bus.instret     = r_instret;
`else
  assign bus.cycle_count = '0;
  assign bus.instret     = '0;
`endif

  assign bus.pc       = r_pc;
  assign bus.estado   = r_state;
  assign bus.imem_req = w_imem_req;
  assign bus.dmem_req = w_dmem_req;
  assign bus.dmem_we  = w_dmem_we;
  assign bus.ir_en    = w_ir_en;
  assign bus.alu_en   = w_alu_en;
  assign bus.rf_we    = w_rf_we;
  assign bus.retire   = w_retire;
  assign bus.halted   = r_halted;
  assign bus.illegal  = r_illegal;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Scoreboard bench for sequenciador_multiciclo (PROG_LEN=8): stimulus pushes the
// expected per-instruction outcome, a negedge monitor pops it on every retire.
module tb_sequenciador_multiciclo;
  import seq_pkg::*;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PROG_LEN = 8;

  logic clk;
  logic rst;

  sequenciador_multiciclo_if #(.XLEN(XLEN)) bus ();

  sequenciador_multiciclo #(
    .XLEN     (XLEN),
    .PROG_LEN (PROG_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc0;
    logic [31:0] pc1;
    int          cycles;
    int          rfwe;
    int          dmem;
    int          we;
    bit          halt;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: per-instruction tallies, compared against the scoreboard on retire.
  int   m_cyc, m_ir, m_alu, m_rf, m_dm, m_we;
  bit   pend = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (pend) begin
      pend = 1'b0;
      chk("next_pc", bus.pc, cur.pc1);
      chk("post_retire_state", 32'(bus.estado), cur.halt ? 32'h6 : 32'h0);
      chk("halted_flag", 32'(bus.halted), 32'(cur.halt));
    end
    if (rst || bus.estado == 3'b111 || bus.estado == 3'b110) begin
      m_cyc = 0; m_ir = 0; m_alu = 0; m_rf = 0; m_dm = 0; m_we = 0;
    end else begin
      m_cyc++;
      m_ir  += int'(bus.ir_en);
      m_alu += int'(bus.alu_en);
      m_rf  += int'(bus.rf_we);
      m_dm  += int'(bus.dmem_req);
      m_we  += int'(bus.dmem_we);
      if (bus.retire) begin
        if (q.size() == 0) begin
          chk("retire_expected", 32'(q.size()), 32'd1);
        end else begin
          cur = q.pop_front();
          chk("retire_pc", bus.pc, cur.pc0);
          chk("instr_cycles", 32'(m_cyc), 32'(cur.cycles));
          chk("ir_en_pulses", 32'(m_ir), 32'd1);
          chk("alu_en_pulses", 32'(m_alu), 32'd1);
          chk("rf_we_pulses", 32'(m_rf), 32'(cur.rfwe));
          chk("dmem_req_cycles", 32'(m_dm), 32'(cur.dmem));
          chk("dmem_we_cycles", 32'(m_we), 32'(cur.we));
          pend = 1'b1;
        end
        m_cyc = 0; m_ir = 0; m_alu = 0; m_rf = 0; m_dm = 0; m_we = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst  = 1'b0;
    m_pc = '0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Drive one instruction from IF entry; expected outcome hand-derived here.
  task automatic do_instr(input logic [2:0] cls, input bit taken, input logic [31:0] off,
                          input int iw, input int dw);
    exp_t e;
    bit   is_mem = (cls == CL_LOAD) || (cls == CL_STORE);
    e.pc0    = m_pc;
    e.pc1    = (cls == CL_BRANCH && taken) ? m_pc + off : m_pc + 32'd1;
    e.cycles = (cls == CL_BRANCH) ? 3 : (cls == CL_LOAD) ? 5 : 4;
    e.cycles += iw + (is_mem ? dw : 0);
    e.rfwe   = (cls == CL_ALU_R || cls == CL_ALU_I || cls == CL_LOAD) ? 1 : 0;
    e.dmem   = is_mem ? dw + 1 : 0;
    e.we     = (cls == CL_STORE) ? dw + 1 : 0;
    e.halt   = (e.pc1 >= 32'(PROG_LEN));
    q.push_back(e);
    m_pc = e.pc1;

    chk("state_if", 32'(bus.estado), 32'h0);
    bus.imem_ready = 1'b0;
    for (int i = 0; i < iw; i++) begin
      tick();
      chk("imem_req_held", 32'(bus.imem_req), 32'd1);
    end
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    chk("state_id", 32'(bus.estado), 32'h1);
    bus.instr_class = cls;
    tick();
    bus.instr_class = 3'd6;
    chk("state_ex", 32'(bus.estado), 32'h2);
    bus.branch_taken = taken;
    bus.branch_off   = off;
    tick();
    bus.branch_taken = 1'b0;
    bus.branch_off   = '0;
    if (is_mem) begin
      chk("state_mem", 32'(bus.estado), 32'h3);
      for (int i = 0; i < dw; i++) tick();
      bus.dmem_ready = 1'b1;
      tick();
      bus.dmem_ready = 1'b0;
    end
    if (e.rfwe == 1) begin
      chk("state_wb", 32'(bus.estado), 32'h4);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.imem_ready   = 1'b0;
    bus.dmem_ready   = 1'b0;
    bus.instr_class  = 3'd6;
    bus.branch_taken = 1'b0;
    bus.branch_off   = '0;
    m_pc             = '0;
    do_reset();

    // Reset values.
    chk("rst_estado", 32'(bus.estado), 32'h7);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
    chk("rst_dmem_req", 32'(bus.dmem_req), 32'h0);
    chk("rst_enables", 32'({bus.ir_en, bus.alu_en, bus.rf_we, bus.retire, bus.dmem_we}), 32'h0);
    chk("rst_status", 32'({bus.halted, bus.illegal}), 32'h0);
    chk("rst_cycle_count", bus.cycle_count, 32'h0);
    chk("rst_instret", bus.instret, 32'h0);

    // Program run: pc 0,1,2,3,4,5 -> 2 -> 7 -> 8 (end of program).
    do_start();
    do_instr(CL_ALU_R,  1'b0, 32'h0,        0, 0);
    do_instr(CL_LOAD,   1'b0, 32'h0,        0, 3);
    do_instr(CL_STORE,  1'b0, 32'h0,        0, 0);
    do_instr(CL_BRANCH, 1'b0, 32'h7,        0, 0);
    do_instr(CL_ALU_I,  1'b0, 32'h0,        2, 0);
    do_instr(CL_BRANCH, 1'b1, 32'hFFFFFFFD, 0, 0);
    do_instr(CL_BRANCH, 1'b1, 32'h5,        0, 0);
    do_instr(CL_ALU_I,  1'b0, 32'h0,        0, 0);
    tick();
    chk("halt_state", 32'(bus.estado), 32'h6);
    chk("halt_pc", bus.pc, 32'h8);
    chk("halt_imem_req", 32'(bus.imem_req), 32'h0);
    chk("halt_illegal", 32'(bus.illegal), 32'h0);
`ifdef SEQ_PERF_EN
    chk("cycle_count", bus.cycle_count, 32'd35);
    chk("instret", bus.instret, 32'd8);
`else
    chk("cycle_count_tied", bus.cycle_count, 32'd0);
    chk("instret_tied", bus.instret, 32'd0);
`endif
    do_start();
    chk("halt_ignores_start", 32'(bus.estado), 32'h6);

    // Branch at pc=5 with offset -6 wraps negative and halts.
    do_reset();
    do_start();
    do_instr(CL_BRANCH, 1'b1, 32'h5,        0, 0);
    do_instr(CL_BRANCH, 1'b1, 32'hFFFFFFFA, 0, 0);
    tick();
    chk("wrap_halt_state", 32'(bus.estado), 32'h6);
    chk("wrap_pc", bus.pc, 32'hFFFFFFFF);

    // Illegal class in ID.
    do_reset();
    do_start();
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    chk("ill_state_id", 32'(bus.estado), 32'h1);
    bus.instr_class = 3'd7;
    tick();
    bus.instr_class = 3'd6;
    chk("ill_state", 32'(bus.estado), 32'h6);
    chk("ill_flag", 32'(bus.illegal), 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("ill_no_activity", 32'({bus.rf_we, bus.dmem_req, bus.imem_req, bus.retire}), 32'h0);
      tick();
    end
    do_start();
    chk("ill_ignores_start", 32'(bus.estado), 32'h6);
    chk("ill_pc", bus.pc, 32'h0);

    // Reset while waiting on imem_ready, then a late ready.
    do_reset();
    do_start();
    do_instr(CL_ALU_R, 1'b0, 32'h0, 0, 0);
    bus.imem_ready = 1'b0;
    tick();
    tick();
    chk("wait_imem_req", 32'(bus.imem_req), 32'h1);
    chk("wait_pc", bus.pc, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pc = '0;
    chk("midrst_state", 32'(bus.estado), 32'h7);
    chk("midrst_imem_req", 32'(bus.imem_req), 32'h0);
    chk("midrst_pc", bus.pc, 32'h0);
    bus.imem_ready = 1'b1;
    tick();
    chk("late_ready_state", 32'(bus.estado), 32'h7);
    chk("late_ready_ir_en", 32'(bus.ir_en), 32'h0);
    bus.imem_ready = 1'b0;
    tick();

    chk("sb_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
